// File: rtl/inv_dir_pipe_pkg.sv
// Shared types and constants for the inverse-direction pipeline.
// Default word geometry is overridable from the command line via the macros below.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

package inv_dir_pipe_pkg;

    localparam int NUM_LANES  = 3;
    localparam int P_WIDTH    = `WIDTH;
    localparam int P_Q_BITS   = `Q_BITS;
    localparam int P_TAG_SIZE = `TAG_SIZE;

    localparam logic [P_WIDTH-1:0] FIX_ONE = P_WIDTH'(1) << P_Q_BITS;
    localparam logic [P_WIDTH-1:0] SAT_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [P_TAG_SIZE-1:0]                 tag;
        logic [NUM_LANES-1:0][P_WIDTH-1:0]     dir;
    } tagged_direction_t;

    function automatic tagged_direction_t unpack_dir(input logic [NUM_LANES*P_WIDTH-1:0] flat,
                                                     input logic [P_TAG_SIZE-1:0]         tag);
        tagged_direction_t t;
        t.tag = tag;
        t.dir = flat;
        return t;
    endfunction

    function automatic logic [NUM_LANES*P_WIDTH-1:0] pack_dir(input tagged_direction_t t);
        return t.dir;
    endfunction

endpackage

// File: rtl/inv_dir_pipe_div.sv
// Multi-cycle signed fixed-point divider: quotient = (dividend << Q_BITS) / divisor,
// truncated toward zero and saturated to the signed WIDTH range.
module inv_dir_pipe_div #(
    parameter int WIDTH  = `WIDTH,
    parameter int Q_BITS = `Q_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             valid,
    output logic             ready,
    output logic [WIDTH-1:0] quotient
);

    localparam int NW = WIDTH + Q_BITS;
    localparam int CW = $clog2(NW + 1);
    localparam logic [NW-1:0] MAX_MAG = {{(Q_BITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [NW-1:0] MIN_MAG = {{Q_BITS{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    logic [NW-1:0]    num_q, num_d;
    logic [NW-2:0]    quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] quot_q, quot_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             q_bit;
    logic [NW-1:0]    q_next;
    logic [WIDTH-1:0] q_sat;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    always_comb begin
        num_d   = num_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        den_d   = den_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        quot_d  = quot_q;

        // Restoring step: the remainder is always below the divisor, so the low WIDTH bits suffice.
        trial  = {rem_q, num_q[NW-1]};
        q_bit  = (trial >= {1'b0, den_q});
        diff   = trial[WIDTH-1:0] - den_q;
        q_next = {quo_q, q_bit};

        if (neg_q) begin
            q_sat = (q_next > MIN_MAG) ? {1'b1, {(WIDTH-1){1'b0}}} : -q_next[WIDTH-1:0];
        end else begin
            q_sat = (q_next > MAX_MAG) ? {1'b0, {(WIDTH-1){1'b1}}} : q_next[WIDTH-1:0];
        end

        if (start) begin
            num_d  = {mag(dividend), {Q_BITS{1'b0}}};
            quo_d  = '0;
            rem_d  = '0;
            den_d  = mag(divisor);
            neg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            cnt_d  = CW'(NW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            num_d = num_q << 1;
            quo_d = q_next[NW-2:0];
            rem_d = q_bit ? diff : trial[WIDTH-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
                quot_d  = q_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            quot_q  <= '0;
        end else begin
            num_q   <= num_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            den_q   <= den_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            quot_q  <= quot_d;
        end
    end

    assign valid    = valid_q;
    assign ready    = !busy_q;
    assign quotient = quot_q;

endmodule

// File: rtl/inv_dir_pipe.sv
// Per-lane reciprocal of a tagged direction vector: one divider per lane, zero lanes
// short-circuit to max positive, results joined and held until the consumer takes them.
module inv_dir_pipe
    import inv_dir_pipe_pkg::*;
#(
    parameter int WIDTH    = `WIDTH,
    parameter int Q_BITS   = `Q_BITS,
    parameter int LANES    = NUM_LANES,
    parameter int TAG_SIZE = `TAG_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_dir,
    input  logic [TAG_SIZE-1:0]    in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_dir,
    output logic [TAG_SIZE-1:0]    out_tag,
    output logic [LANES-1:0]       out_zero_mask
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << Q_BITS;
    localparam logic [WIDTH-1:0] SAT = {1'b0, {(WIDTH-1){1'b1}}};

    state_t                        state_q, state_d;
    logic [LANES-1:0]              sticky_q, sticky_d;
    logic                          join_q, join_d;
    logic [LANES-1:0][WIDTH-1:0]   res_q, res_d;
    logic [TAG_SIZE-1:0]           tag_q, tag_d;
    logic [LANES-1:0]              mask_q, mask_d;
    logic [LANES-1:0][WIDTH-1:0]   out_dir_q, out_dir_d;
    logic [TAG_SIZE-1:0]           out_tag_q, out_tag_d;
    logic [LANES-1:0]              out_mask_q, out_mask_d;
    logic                          out_valid_q, out_valid_d;

    logic                          accept;
    logic [LANES-1:0]              zero, lanes_done;
    logic [LANES-1:0]              div_start, div_valid, div_ready;
    logic [LANES-1:0][WIDTH-1:0]   div_quot;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        inv_dir_pipe_div #(
            .WIDTH  (WIDTH),
            .Q_BITS (Q_BITS)
        ) u_div (
            .clk      (clk),
            .reset    (reset),
            .start    (div_start[i]),
            .dividend (ONE),
            .divisor  (in_dir[i*WIDTH +: WIDTH]),
            .valid    (div_valid[i]),
            .ready    (div_ready[i]),
            .quotient (div_quot[i])
        );

        a_start_idle: assert property (@(posedge clk) disable iff (reset) div_start[i] |-> div_ready[i]);
    end

    always_comb begin
        state_d     = state_q;
        sticky_d    = sticky_q;
        join_d      = join_q;
        res_d       = res_q;
        tag_d       = tag_q;
        mask_d      = mask_q;
        out_dir_d   = out_dir_q;
        out_tag_d   = out_tag_q;
        out_mask_d  = out_mask_q;
        out_valid_d = out_valid_q;

        zero = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            zero[i] = (in_dir[i*WIDTH +: WIDTH] == '0);
        end

        in_ready   = (state_q == IDLE) || (state_q == DONE && out_ready);
        accept     = in_valid && in_ready;
        div_start  = accept ? ~zero : '0;
        lanes_done = sticky_q | div_valid;

        case (state_q)
            BUSY: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (div_valid[i]) res_d[i] = div_quot[i];
                end
                sticky_d = lanes_done;
                // join_q marks a completed join; publishing one edge later keeps DONE and out_valid aligned.
                if (join_q) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_dir_d   = res_q;
                    out_tag_d   = tag_q;
                    out_mask_d  = mask_q;
                    join_d      = 1'b0;
                end else begin
                    join_d = &lanes_done;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            state_d  = BUSY;
            tag_d    = in_tag;
            mask_d   = zero;
            sticky_d = zero;
            join_d   = 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                res_d[i] = zero[i] ? SAT : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sticky_q    <= '0;
            join_q      <= 1'b0;
            res_q       <= '0;
            tag_q       <= '0;
            mask_q      <= '0;
            out_dir_q   <= '0;
            out_tag_q   <= '0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sticky_q    <= sticky_d;
            join_q      <= join_d;
            res_q       <= res_d;
            tag_q       <= tag_d;
            mask_q      <= mask_d;
            out_dir_q   <= out_dir_d;
            out_tag_q   <= out_tag_d;
            out_mask_q  <= out_mask_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_dir       = out_dir_q;
    assign out_tag       = out_tag_q;
    assign out_zero_mask = out_mask_q;

endmodule

// File: tb/tb_inv_dir_pipe.sv
// Bench for inv_dir_pipe: directed and randomized directions checked against a
// reciprocal model computed with plain integer arithmetic.
module tb_inv_dir_pipe;
    import inv_dir_pipe_pkg::*;

    localparam int W = 16;
    localparam int Q = 12;
    localparam int L = 3;
    localparam int T = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [L*W-1:0] in_dir;
    logic [T-1:0]   in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] out_dir;
    logic [T-1:0]   out_tag;
    logic [L-1:0]   out_zero_mask;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    inv_dir_pipe #(
        .WIDTH    (W),
        .Q_BITS   (Q),
        .LANES    (L),
        .TAG_SIZE (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dir        (in_dir),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_dir       (out_dir),
        .out_tag       (out_tag),
        .out_zero_mask (out_zero_mask)
    );

    function automatic logic [W-1:0] ref_inv(input logic [W-1:0] d);
        longint dv;
        longint q;
        if (d == '0) return SAT_MAX;
        dv = longint'($signed(d));
        q  = (longint'(FIX_ONE) <<< Q) / dv;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[W-1:0];
    endfunction

    function automatic logic [L*W-1:0] ref_dir(input logic [L*W-1:0] d);
        logic [L*W-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = ref_inv(d[i*W +: W]);
        return r;
    endfunction

    function automatic logic [L-1:0] ref_mask(input logic [L*W-1:0] d);
        logic [L-1:0] m;
        for (int i = 0; i < L; i++) m[i] = (d[i*W +: W] == '0);
        return m;
    endfunction

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (out_valid !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_dir = '0; in_tag = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
        n_checks++;
        if ({out_valid, out_dir, out_tag, out_zero_mask} !== '0)
            $display("FAIL reset_outputs: got v=%b d=%h t=%h m=%b expected all 0",
                     out_valid, out_dir, out_tag, out_zero_mask);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [L*W-1:0] dv [5];
        logic [T-1:0]   tg [5];
        int cyc;
        dv = '{48'hF000_2000_1000, 48'h0000_4000_0000, 48'h8000_0200_FE00,
               48'h0001_FFFF_7FFF, 48'h0201_FDFF_0C00};
        tg = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_dir = dv[k]; in_tag = tg[k]; in_valid = 1'b1;
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL dir%0d_ready: got %b expected 1", k, in_ready);
            else n_pass++;
            @(negedge clk);
            in_valid = 1'b0; in_dir = 48'({$urandom(), $urandom()}); in_tag = 8'($urandom());
            wait_valid(cyc);
            n_checks++;
            if (cyc < 0) $display("FAIL dir%0d_timeout: got no out_valid expected out_valid", k);
            else n_pass++;
            n_checks++;
            if ({out_dir, out_tag, out_zero_mask} !== {ref_dir(dv[k]), tg[k], ref_mask(dv[k])})
                $display("FAIL dir%0d_result: got %h/%h/%b expected %h/%h/%b", k, out_dir, out_tag,
                         out_zero_mask, ref_dir(dv[k]), tg[k], ref_mask(dv[k]));
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL dir%0d_consume: got out_valid %b expected 0", k, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_all_zero();
        logic [2:0] seen;
        @(negedge clk);
        in_dir = '0; in_tag = 8'h7E; in_valid = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            seen[e] = out_valid;
        end
        n_checks++;
        if (seen !== 3'b100) $display("FAIL zero_latency: got valid after edges 1..3 = %b expected 100", seen);
        else n_pass++;
        n_checks++;
        if ({out_dir, out_tag, out_zero_mask} !== {48'h7FFF_7FFF_7FFF, 8'h7E, 3'b111})
            $display("FAIL zero_result: got %h/%h/%b expected 7fff7fff7fff/7e/111",
                     out_dir, out_tag, out_zero_mask);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [L*W-1:0] a, b;
        int cyc;
        a = 48'h0C00_F800_0300; b = 48'h1800_0000_E000;
        out_ready = 1'b0;
        @(negedge clk);
        in_dir = a; in_tag = 8'hA1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(cyc);
        n_checks++;
        if (cyc < 0) $display("FAIL stall_timeout: got no out_valid expected out_valid");
        else n_pass++;
        in_dir = b; in_tag = 8'hB2; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_dir, out_tag, in_ready} !== {1'b1, ref_dir(a), 8'hA1, 1'b0})
                $display("FAIL stall_hold%0d: got v=%b d=%h t=%h r=%b expected v=1 d=%h t=a1 r=0",
                         c, out_valid, out_dir, out_tag, in_ready, ref_dir(a));
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(cyc);
        n_checks++;
        if (cyc < 0 || {out_dir, out_tag, out_zero_mask} !== {ref_dir(b), 8'hB2, ref_mask(b)})
            $display("FAIL stall_second: got %h/%h/%b expected %h/b2/%b", out_dir, out_tag,
                     out_zero_mask, ref_dir(b), ref_mask(b));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [L*W-1:0] a, b;
        int cyc;
        a = 48'h2000_1000_0800; b = 48'hF000_0000_4000;
        out_ready = 1'b1;
        @(negedge clk);
        in_dir = a; in_tag = 8'h01; in_valid = 1'b1;
        @(negedge clk);
        in_dir = b; in_tag = 8'h02;
        wait_valid(cyc);
        n_checks++;
        if (cyc < 0 || {out_dir, out_tag, in_ready} !== {ref_dir(a), 8'h01, 1'b1})
            $display("FAIL b2b_first: got %h/%h ready=%b expected %h/01 ready=1",
                     out_dir, out_tag, in_ready, ref_dir(a));
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00)
            $display("FAIL b2b_no_bubble: got valid=%b ready=%b expected 0 0", out_valid, in_ready);
        else n_pass++;
        wait_valid(cyc);
        n_checks++;
        if (cyc < 0 || {out_dir, out_tag, out_zero_mask} !== {ref_dir(b), 8'h02, ref_mask(b)})
            $display("FAIL b2b_second: got %h/%h/%b expected %h/02/%b", out_dir, out_tag,
                     out_zero_mask, ref_dir(b), ref_mask(b));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [L*W-1:0] d;
        logic           any;
        int cyc;
        d = 48'h0400_0800_1000;
        out_ready = 1'b1;
        @(negedge clk);
        in_dir = d; in_tag = 8'hC3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midbusy_ready_in_reset: got %b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midbusy_ready_after: got %b expected 1", in_ready);
        else n_pass++;
        any = 1'b0;
        repeat (60) begin @(negedge clk); any |= out_valid; end
        n_checks++;
        if (any !== 1'b0) $display("FAIL midbusy_discard: got out_valid pulse %b expected 0", any);
        else n_pass++;

        out_ready = 1'b0;
        in_dir = d; in_tag = 8'hD4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(cyc);
        n_checks++;
        if (cyc < 0 || {out_dir, out_tag} !== {ref_dir(d), 8'hD4})
            $display("FAIL after_reset_txn: got %h/%h expected %h/d4", out_dir, out_tag, ref_dir(d));
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_dir, out_tag, out_zero_mask} !== '0)
            $display("FAIL middone_clear: got v=%b d=%h t=%h m=%b expected all 0",
                     out_valid, out_dir, out_tag, out_zero_mask);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        any = 1'b0;
        repeat (40) begin @(negedge clk); any |= out_valid; end
        n_checks++;
        if (any !== 1'b0) $display("FAIL middone_discard: got out_valid pulse %b expected 0", any);
        else n_pass++;
    endtask

    task automatic test_random();
        tagged_direction_t t;
        logic [W-1:0]      v;
        int cyc;
        int hold;
        for (int n = 0; n < 25; n++) begin
            for (int l = 0; l < L; l++) begin
                case ($urandom_range(0, 3))
                    0: v = '0;
                    1: begin
                        v = 16'($urandom_range(1, 1023));
                        if ($urandom_range(0, 1) == 1) v = -v;
                    end
                    default: v = 16'($urandom());
                endcase
                t.dir[l] = v;
            end
            t.tag = 8'($urandom());
            t = unpack_dir(pack_dir(t), t.tag);
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            @(negedge clk);
            in_dir = pack_dir(t); in_tag = t.tag; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; in_dir = 48'({$urandom(), $urandom()});
            wait_valid(cyc);
            repeat (hold) @(negedge clk);
            n_checks++;
            if (cyc < 0 || {out_valid, out_dir, out_tag, out_zero_mask} !==
                           {1'b1, ref_dir(pack_dir(t)), t.tag, ref_mask(pack_dir(t))})
                $display("FAIL rand%0d: in=%h got v=%b %h/%h/%b expected %h/%h/%b", n, pack_dir(t),
                         out_valid, out_dir, out_tag, out_zero_mask, ref_dir(pack_dir(t)), t.tag,
                         ref_mask(pack_dir(t)));
            else n_pass++;
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_all_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
